// File: rtl/req_arbiter_8ch_if.sv
// req_arbiter_8ch_if -- request/grant bundle between eight requesters and the arbiter.
//   req_i[7:0]      per-channel request, level-sensitive
//   release_i       current owner ends its tenure
//   gnt_valid_o     gnt_idx_o carries a live grant
//   gnt_idx_o[2:0]  binary index of the granted channel
//   timeout_o       one-cycle pulse on a forced release
// Modports: master = requester side, slave = arbiter side.
interface req_arbiter_8ch_if;
  logic [7:0] req_i;
  logic       release_i;
  logic       gnt_valid_o;
  logic [2:0] gnt_idx_o;
  logic       timeout_o;

  modport master (
    output req_i,
    output release_i,
    input  gnt_valid_o,
    input  gnt_idx_o,
    input  timeout_o
  );

  modport slave (
    input  req_i,
    input  release_i,
    output gnt_valid_o,
    output gnt_idx_o,
    output timeout_o
  );
endinterface

// File: rtl/req_arbiter_8ch.sv
// req_arbiter_8ch -- 8-channel round-robin arbiter with explicit release.
//   clk      single clock, rising edge
//   rst_n    asynchronous active-low reset
//   bus      req_arbiter_8ch_if.slave (req_i, release_i, gnt_valid_o, gnt_idx_o, timeout_o)
// Parameter HOLD_MAX (1..255): maximum grant length in cycles when the
// optional hold timeout is built in.
// Optional feature macro: ARB_TIMEOUT_EN adds the hold counter and forced
// release; without it timeout_o is tied low and grants last until release_i.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no live grant; search req_i from ptr, grant on next edge
// ST_GRANT | grant held on gnt_idx_o until release_i (or hold timeout)
module req_arbiter_8ch #(
  parameter int unsigned HOLD_MAX = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  req_arbiter_8ch_if.slave  bus
);

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("req_arbiter_8ch: HOLD_MAX must be within 1..255");
  end

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t     r_state, w_state_nx;
  logic [2:0] r_ptr, w_ptr_nx;
  logic [2:0] r_idx, w_idx_nx;
  logic       r_valid, w_valid_nx;
  logic [2:0] w_winner;
  logic       w_found;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] LP_HOLD_LAST = 8'(HOLD_MAX - 1);
  logic [7:0] r_hold, w_hold_nx;
  logic       r_tmo, w_tmo_nx;
`endif

  // Rotating search: first set request at or above ptr, wrapping 7 -> 0.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_ptr;
    for (int i = 0; i < 8; i++) begin
      if (!w_found && bus.req_i[r_ptr + 3'(i)]) begin
        w_found  = 1'b1;
        w_winner = r_ptr + 3'(i);
      end
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_ptr_nx   = r_ptr;
    w_idx_nx   = r_idx;
    w_valid_nx = r_valid;
`ifdef ARB_TIMEOUT_EN
    w_hold_nx  = r_hold;
    w_tmo_nx   = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nx = ST_GRANT;
          w_idx_nx   = w_winner;
          w_valid_nx = 1'b1;
`ifdef ARB_TIMEOUT_EN
          w_hold_nx  = 8'd0;
`endif
        end
      end
      ST_GRANT: begin
        // Releasing always lands in IDLE, which is what creates the
        // one-cycle bubble and moves the owner to lowest priority.
        if (bus.release_i) begin
          w_state_nx = ST_IDLE;
          w_ptr_nx   = r_idx + 3'd1;
          w_valid_nx = 1'b0;
`ifdef ARB_TIMEOUT_EN
        end else if (r_hold == LP_HOLD_LAST) begin
          w_state_nx = ST_IDLE;
          w_ptr_nx   = r_idx + 3'd1;
          w_valid_nx = 1'b0;
          w_tmo_nx   = 1'b1;
        end else begin
          w_hold_nx  = r_hold + 8'd1;
`endif
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_valid_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= 3'd0;
      r_idx   <= 3'd0;
      r_valid <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_hold  <= 8'd0;
      r_tmo   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nx;
      r_ptr   <= w_ptr_nx;
      r_idx   <= w_idx_nx;
      r_valid <= w_valid_nx;
`ifdef ARB_TIMEOUT_EN
      r_hold  <= w_hold_nx;
      r_tmo   <= w_tmo_nx;
`endif
    end
  end

  assign bus.gnt_valid_o = r_valid;
  assign bus.gnt_idx_o   = r_idx;
`ifdef ARB_TIMEOUT_EN
  assign bus.timeout_o   = r_tmo;
`else
  assign bus.timeout_o   = 1'b0;
`endif

endmodule

// File: tb/tb_req_arbiter_8ch.sv
// tb_req_arbiter_8ch -- directed scenarios plus random traffic, every cycle
// compared against a round-robin reference model.
module tb_req_arbiter_8ch;

`ifdef ARB_TIMEOUT_EN
  localparam int TB_HOLD = 4;
  localparam bit TMO_EN  = 1'b1;
`else
  localparam int TB_HOLD = 255;
  localparam bit TMO_EN  = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  req_arbiter_8ch_if arb ();

  req_arbiter_8ch #(.HOLD_MAX(TB_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (arb)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an owner plus a priority pointer; a grant ends on
  // release or after TB_HOLD visible cycles, and the search restarts one
  // channel past the previous owner.
  logic       m_valid;
  logic [2:0] m_idx;
  logic [2:0] m_ptr;
  int         m_cycles;
  logic       m_tmo;

  function automatic logic [3:0] pick(input logic [2:0] ptr, input logic [7:0] req);
    for (int k = 0; k < 8; k++) begin
      int c;
      c = (int'(ptr) + k) % 8;
      if (req[c]) return {1'b1, 3'(c)};
    end
    return 4'b0000;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid  <= 1'b0;
      m_idx    <= 3'd0;
      m_ptr    <= 3'd0;
      m_cycles <= 0;
      m_tmo    <= 1'b0;
    end else begin
      m_tmo <= 1'b0;
      if (m_valid) begin
        if (arb.release_i || (TMO_EN && (m_cycles + 1 >= TB_HOLD))) begin
          m_valid <= 1'b0;
          m_ptr   <= 3'((int'(m_idx) + 1) % 8);
          m_tmo   <= !arb.release_i;
        end else begin
          m_cycles <= m_cycles + 1;
        end
      end else if (pick(m_ptr, arb.req_i) != 4'b0000) begin
        m_valid  <= 1'b1;
        m_idx    <= pick(m_ptr, arb.req_i) & 4'h7;
        m_cycles <= 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_valid", 32'(arb.gnt_valid_o), 32'(m_valid));
    chk("cyc_idx",   32'(arb.gnt_idx_o),   32'(m_idx));
    chk("cyc_tmo",   32'(arb.timeout_o),   32'(m_tmo));
  end

  task automatic do_reset();
    rst_n         = 1'b0;
    arb.req_i     = 8'h00;
    arb.release_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    arb.req_i     = 8'h00;
    arb.release_i = 1'b0;

    do_reset();
    chk("rst_valid", 32'(arb.gnt_valid_o), 0);
    chk("rst_idx",   32'(arb.gnt_idx_o),   0);
    chk("rst_tmo",   32'(arb.timeout_o),   0);

    // single request, one-cycle latency
    arb.req_i = 8'h01;
    @(negedge clk);
    chk("first_valid", 32'(arb.gnt_valid_o), 1);
    chk("first_idx",   32'(arb.gnt_idx_o),   0);
    arb.req_i = 8'h00; arb.release_i = 1'b1;
    @(negedge clk);
    arb.release_i = 1'b0;
    chk("first_rel_valid", 32'(arb.gnt_valid_o), 0);

    // all requesting: 0..7,0 with a bubble after every release
    do_reset();
    arb.req_i = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      chk("rr_valid", 32'(arb.gnt_valid_o), 1);
      chk("rr_idx",   32'(arb.gnt_idx_o),   32'(k % 8));
      arb.release_i = 1'b1;
      @(negedge clk);
      arb.release_i = 1'b0;
      chk("rr_bubble", 32'(arb.gnt_valid_o), 0);
    end

    // owner drops its request: grant holds until release
    do_reset();
    arb.req_i = 8'h20;
    @(negedge clk);
    chk("hold_idx", 32'(arb.gnt_idx_o), 5);
    arb.req_i = 8'h00;
    repeat (3) begin
      @(negedge clk);
      chk("hold_valid_kept", 32'(arb.gnt_valid_o), 1);
      chk("hold_idx_kept",   32'(arb.gnt_idx_o),   5);
    end
    arb.req_i = 8'h11; arb.release_i = 1'b1;
    @(negedge clk);
    arb.release_i = 1'b0;
    chk("hold_bubble", 32'(arb.gnt_valid_o), 0);
    chk("hold_idx_retained", 32'(arb.gnt_idx_o), 5);
    @(negedge clk);
    chk("hold_next_valid", 32'(arb.gnt_valid_o), 1);
    chk("hold_next_idx",   32'(arb.gnt_idx_o),   0);
    arb.req_i = 8'h00; arb.release_i = 1'b1;
    @(negedge clk);
    arb.release_i = 1'b0;

    // reset in the middle of a grant
    do_reset();
    arb.req_i = 8'h08;
    @(negedge clk);
    chk("mid_rst_idx", 32'(arb.gnt_idx_o), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid_now", 32'(arb.gnt_valid_o), 0);
    chk("mid_rst_idx_now",   32'(arb.gnt_idx_o),   0);
    chk("mid_rst_tmo_now",   32'(arb.timeout_o),   0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 32'(arb.gnt_valid_o), 1);
    chk("post_rst_idx",   32'(arb.gnt_idx_o),   3);

`ifdef ARB_TIMEOUT_EN
    // forced release after HOLD_MAX = 4 cycles
    do_reset();
    arb.req_i = 8'h04;
    @(negedge clk);
    chk("to_grant_idx", 32'(arb.gnt_idx_o), 2);
    chk("to_tmo_c0",    32'(arb.timeout_o), 0);
    arb.req_i = 8'h14;
    repeat (3) begin
      @(negedge clk);
      chk("to_valid_held", 32'(arb.gnt_valid_o), 1);
      chk("to_tmo_low",    32'(arb.timeout_o),   0);
    end
    @(negedge clk);
    chk("to_pulse",       32'(arb.timeout_o),   1);
    chk("to_valid_drop",  32'(arb.gnt_valid_o), 0);
    @(negedge clk);
    chk("to_pulse_end",   32'(arb.timeout_o),   0);
    chk("to_next_valid",  32'(arb.gnt_valid_o), 1);
    chk("to_next_idx",    32'(arb.gnt_idx_o),   4);
    // release lands exactly in the timeout cycle
    repeat (3) @(negedge clk);
    arb.release_i = 1'b1;
    @(negedge clk);
    arb.release_i = 1'b0;
    chk("to_rel_tmo",   32'(arb.timeout_o),   0);
    chk("to_rel_valid", 32'(arb.gnt_valid_o), 0);
    @(negedge clk);
    chk("to_rel_tmo2",  32'(arb.timeout_o),   0);
    chk("to_rel_next",  32'(arb.gnt_idx_o),   2);
    chk("to_rel_nextv", 32'(arb.gnt_valid_o), 1);
    arb.req_i = 8'h00; arb.release_i = 1'b1;
    @(negedge clk);
    arb.release_i = 1'b0;
`endif

    // random traffic, occasional asynchronous reset pulses
    do_reset();
    repeat (3000) begin
      @(negedge clk);
      if ($urandom_range(0, 4) == 0)
        arb.req_i = 8'h00;
      else if ($urandom_range(0, 2) == 0)
        arb.req_i = 8'($urandom);
      else
        arb.req_i = 8'($urandom) & 8'($urandom);
      arb.release_i = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 299) == 0) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/req_arbiter_8ch.md
REQ_ARBITER_8CH -- requirements
Module: req_arbiter_8ch

Interface
REQ-001 The block SHALL have parameter HOLD_MAX, default 255, giving the maximum grant hold in cycles (legal range 1..255; used only with ARB_TIMEOUT_EN).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port req_i, input, 8 bits: per-channel request, level-sensitive.
REQ-005 The block SHALL have port release_i, input, 1 bit: the granted owner ends its tenure.
REQ-006 The block SHALL have port gnt_valid_o, output, 1 bit: gnt_idx_o carries a live grant.
REQ-007 The block SHALL have port gnt_idx_o, output, 3 bits: binary index of the granted channel, which drives the downstream 3-to-8 select decoder.
REQ-008 The block SHALL have port timeout_o, output, 1 bit: one-cycle pulse on a forced release.

Function
REQ-009 The block SHALL implement a two-state FSM: IDLE and GRANT.
REQ-010 In IDLE with req_i == 0, the block SHALL stay in IDLE with gnt_valid_o = 0.
REQ-011 In IDLE with req_i != 0, the block SHALL select the first set bit searching upward from ptr, wrapping 7 -> 0.
- On the next edge: register the winner into gnt_idx_o, set gnt_valid_o = 1, enter GRANT.
- Latency: 1 cycle from request to grant.
REQ-012 In GRANT, gnt_idx_o and gnt_valid_o SHALL hold stable regardless of req_i changes, including a drop of the owner's request.
REQ-013 In GRANT with release_i = 1, the block SHALL, on the next edge:
- set ptr = gnt_idx_o + 1 (mod 8);
- clear gnt_valid_o;
- enter IDLE.
REQ-014 After every release, the block SHALL keep gnt_valid_o low for exactly one cycle (one-cycle bubble) before any new grant.
REQ-015 The block SHALL ignore release_i while in IDLE.
REQ-016 While gnt_valid_o = 0, gnt_idx_o SHALL retain its last value; downstream gates the decoder with gnt_valid_o.
REQ-017 The priority pointer ptr SHALL be 3 bits wide, and only a release (normal or forced) SHALL update it.
REQ-018 A channel re-requesting immediately after release SHALL have lowest priority among active requesters, guaranteeing starvation-freedom across all 8 channels.

Reset
REQ-019 While rst_n = 0, the block SHALL asynchronously force:
- state = IDLE;
- ptr = 0;
- gnt_idx_o = 0;
- gnt_valid_o = 0;
- timeout_o = 0;
- hold counter = 0.
REQ-020 Reset asserted mid-grant SHALL drop gnt_valid_o immediately, with no release pulse and no timeout pulse.
REQ-021 After rst_n deasserts, the first grant SHALL follow the REQ-011 rule with ptr = 0.

Configuration
REQ-022 With macro ARB_TIMEOUT_EN defined, the block SHALL include an 8-bit hold counter.
- The counter clears on entry to GRANT and increments each GRANT cycle.
- When it reaches HOLD_MAX - 1 without release_i, the next edge performs a release per REQ-013 and pulses timeout_o for one cycle.
REQ-023 With ARB_TIMEOUT_EN defined, a release_i coinciding with the timeout cycle SHALL produce exactly one release, and timeout_o SHALL NOT pulse.
REQ-024 Without ARB_TIMEOUT_EN, the block SHALL have no hold counter, timeout_o SHALL be tied 0, and grants SHALL last until release_i.

Verification
REQ-025 The bench SHALL cover: after reset, req_i = 8'b0000_0001 -> one cycle later gnt_valid_o = 1, gnt_idx_o = 0.
REQ-026 The bench SHALL cover: req_i = 8'hFF held, release_i pulsed each grant -> grant sequence 0,1,2,...,7,0, each grant separated by a one-cycle gnt_valid_o = 0 bubble.
REQ-027 The bench SHALL cover: grant on channel 5, req_i[5] dropped, release_i not asserted -> gnt_idx_o = 5 and gnt_valid_o = 1 held; release_i with req_i = 8'b0001_0001 -> next grant is index 0.
REQ-028 The bench SHALL cover: grant on channel 3, rst_n pulsed low mid-grant -> gnt_valid_o = 0 immediately; after reset, req_i = 8'h08 -> grant index 3.
REQ-029 The bench SHALL cover, with ARB_TIMEOUT_EN and HOLD_MAX = 4: grant on channel 2 with no release -> timeout_o pulses once, 4 cycles after gnt_valid_o rose, and the next grant skips to the next requester.
REQ-030 The bench SHALL cover, with ARB_TIMEOUT_EN: release_i asserted exactly in the timeout cycle -> single release, timeout_o = 0.
